// File: rtl/clock_gen_pkg.sv
// Shared types and helpers for the PLL clock generator / lock supervisor.
// Imported by clock_gen_pll and clock_gen_mgr.
package clock_gen_pkg;

    localparam int MAX_PLL_OUT = 6;

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } cg_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clock_gen_pll.sv
// PLL wrapper: PLLE2_ADV + BUFGs when CLKGEN_XILINX_PLL is defined,
// otherwise a synthesizable fabric divider model with a modelled lock delay.
module clock_gen_pll
    import clock_gen_pkg::*;
#(
    parameter int  NUM_OUT                   = 3,
    parameter real CLKIN_PERIOD              = 5.000,
    parameter int  FB_MULT                   = 8,
    parameter int  DIV_CLK                   = 1,
    parameter int  OUT_DIVIDE [MAX_PLL_OUT]  = '{2, 2, 8, 2, 2, 2},
    parameter real OUT_PHASE  [MAX_PLL_OUT]  = '{90.0, 0.0, 0.0, 0.0, 0.0, 0.0}
) (
    input  logic                   clkin,
    input  logic                   rst,
    output logic                   locked,
    output logic [MAX_PLL_OUT-1:0] clk_out
);

`ifdef CLKGEN_XILINX_PLL

    function automatic int div_of(input int i);
        return (i < NUM_OUT) ? OUT_DIVIDE[i] : 2;
    endfunction

    function automatic real ph_of(input int i);
        return (i < NUM_OUT) ? OUT_PHASE[i] : 0.0;
    endfunction

    logic                   clkfb;
    logic                   clkfb_buf;
    logic [MAX_PLL_OUT-1:0] clk_raw;

    PLLE2_ADV #(
        .BANDWIDTH      ("OPTIMIZED"),
        .CLKIN1_PERIOD  (CLKIN_PERIOD),
        .CLKFBOUT_MULT  (FB_MULT),
        .DIVCLK_DIVIDE  (DIV_CLK),
        .CLKOUT0_DIVIDE (div_of(0)),
        .CLKOUT1_DIVIDE (div_of(1)),
        .CLKOUT2_DIVIDE (div_of(2)),
        .CLKOUT3_DIVIDE (div_of(3)),
        .CLKOUT4_DIVIDE (div_of(4)),
        .CLKOUT5_DIVIDE (div_of(5)),
        .CLKOUT0_PHASE  (ph_of(0)),
        .CLKOUT1_PHASE  (ph_of(1)),
        .CLKOUT2_PHASE  (ph_of(2)),
        .CLKOUT3_PHASE  (ph_of(3)),
        .CLKOUT4_PHASE  (ph_of(4)),
        .CLKOUT5_PHASE  (ph_of(5))
    ) u_pll (
        .CLKIN1   (clkin),
        .CLKIN2   (1'b0),
        .CLKINSEL (1'b1),
        .CLKFBIN  (clkfb_buf),
        .CLKFBOUT (clkfb),
        .CLKOUT0  (clk_raw[0]),
        .CLKOUT1  (clk_raw[1]),
        .CLKOUT2  (clk_raw[2]),
        .CLKOUT3  (clk_raw[3]),
        .CLKOUT4  (clk_raw[4]),
        .CLKOUT5  (clk_raw[5]),
        .RST      (rst),
        .PWRDWN   (1'b0),
        .LOCKED   (locked),
        .DADDR    (7'd0),
        .DCLK     (1'b0),
        .DEN      (1'b0),
        .DI       (16'd0),
        .DWE      (1'b0),
        .DO       (),
        .DRDY     ()
    );

    BUFG u_fb_bufg (.I(clkfb), .O(clkfb_buf));

    for (genvar i = 0; i < MAX_PLL_OUT; i++) begin : g_bufg
        BUFG u_bufg (.I(clk_raw[i]), .O(clk_out[i]));
    end

`else

    // Lock time scales with the feedback loop and a fixed ~100 ns settle.
    localparam int LOCK_DLY = FB_MULT * DIV_CLK + int'(100.0 / CLKIN_PERIOD);

    logic [15:0] lk_cnt;

    // Hold lock low during and for LOCK_DLY cycles after PLL reset.
    always_ff @(posedge clkin) begin
        if (rst)
            lk_cnt <= '0;
        else if (lk_cnt != 16'(LOCK_DLY))
            lk_cnt <= lk_cnt + 16'd1;
    end

    assign locked = (lk_cnt == 16'(LOCK_DLY));

    for (genvar i = 0; i < MAX_PLL_OUT; i++) begin : g_out
        if (i < NUM_OUT) begin : g_on
            localparam int D = OUT_DIVIDE[i];
            localparam int P = int'(OUT_PHASE[i] * real'(D) / 360.0) % D;

            logic [7:0] cnt;

            // Free-running divider, preloaded to approximate the phase offset.
            always_ff @(posedge clkin) begin
                if (rst)
                    cnt <= 8'(P);
                else
                    cnt <= (cnt == 8'(D - 1)) ? 8'd0 : cnt + 8'd1;
            end

            assign clk_out[i] = (D == 1) ? clkin : (cnt < 8'(D / 2));
        end else begin : g_off
            assign clk_out[i] = 1'b0;
        end
    end

`endif

endmodule

// File: rtl/clock_gen_mgr.sv
// PLL clock generator with lock supervisor and staggered reset release.
// CLKGEN_LOSS_CNT_EN adds a saturating 16-bit RUN lock-loss counter port.
module clock_gen_mgr
    import clock_gen_pkg::*;
#(
    parameter int  NUM_OUT                   = 3,
    parameter real CLKIN_PERIOD              = 5.000,
    parameter int  FB_MULT                   = 8,
    parameter int  DIV_CLK                   = 1,
    parameter int  OUT_DIVIDE [MAX_PLL_OUT]  = '{2, 2, 8, 2, 2, 2},
    parameter real OUT_PHASE  [MAX_PLL_OUT]  = '{90.0, 0.0, 0.0, 0.0, 0.0, 0.0},
    parameter int  RST_CYCLES                = 16,
    parameter int  LOCK_TIMEOUT              = 65536,
    parameter int  LOCK_STABLE               = 1024,
    parameter int  RELEASE_GAP               = 8,
    parameter int  MAX_RETRY                 = 4,
    localparam int RW = $clog2(MAX_RETRY + 1)
) (
    input  logic               clkin,
    input  logic               reset,
    output logic [NUM_OUT-1:0] clk_out,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               locked,
    output logic               fail,
    output cg_state_t          state,
`ifdef CLKGEN_LOSS_CNT_EN
    output logic [15:0]        loss_cnt,
`endif
    output logic [RW-1:0]      retry_cnt
);

    localparam int TMAX = max2(max2(RST_CYCLES, LOCK_TIMEOUT),
                               max2(LOCK_STABLE, RELEASE_GAP));
    localparam int TW = $clog2(TMAX + 1);

    localparam logic [TW-1:0] T_RST  = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] T_LOCK = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] T_STAB = TW'(LOCK_STABLE - 1);
    localparam logic [TW-1:0] T_GAP  = TW'(RELEASE_GAP - 1);

    logic                   pll_rst;
    logic                   pll_locked;
    logic [MAX_PLL_OUT-1:0] pll_clk;
    logic                   unused_clk;

    logic                   lock_meta;
    logic                   lock_s;
    logic [TW-1:0]          timer;
    logic [TW-1:0]          t_inc;
    logic [RW-1:0]          retry_nxt;
    logic [NUM_OUT-1:0]     rst_shl;

    clock_gen_pll #(
        .NUM_OUT      (NUM_OUT),
        .CLKIN_PERIOD (CLKIN_PERIOD),
        .FB_MULT      (FB_MULT),
        .DIV_CLK      (DIV_CLK),
        .OUT_DIVIDE   (OUT_DIVIDE),
        .OUT_PHASE    (OUT_PHASE)
    ) u_pll (
        .clkin   (clkin),
        .rst     (pll_rst),
        .locked  (pll_locked),
        .clk_out (pll_clk)
    );

    assign clk_out    = pll_clk[NUM_OUT-1:0];
    assign unused_clk = ^pll_clk;

    assign pll_rst = (state == RST_PLL) || (state == FAIL);
    assign locked  = (state == RUN);
    assign fail    = (state == FAIL);

    assign t_inc     = (&timer) ? timer : timer + TW'(1);
    assign retry_nxt = retry_cnt + RW'(1);
    assign rst_shl   = rst_out << 1;

    // Two-flop synchroniser for the asynchronous PLL LOCKED.
    always_ff @(posedge clkin) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // Supervisor FSM: PLL reset pulse, lock wait/qualify, staggered release.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state     <= RST_PLL;
            timer     <= '0;
            retry_cnt <= '0;
            rst_out   <= '1;
        end else begin
            unique case (state)
                RST_PLL: begin
                    if (timer >= T_RST) begin
                        state <= WAIT_LOCK;
                        timer <= '0;
                    end else begin
                        timer <= t_inc;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= STABLE;
                        timer <= TW'(1);
                    end else if (timer >= T_LOCK) begin
                        timer     <= '0;
                        retry_cnt <= retry_nxt;
                        state     <= (retry_nxt == RW'(MAX_RETRY)) ? FAIL : RST_PLL;
                    end else begin
                        timer <= t_inc;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        timer <= '0;
                    end else if (timer >= T_STAB) begin
                        state   <= RELEASE;
                        timer   <= '0;
                        rst_out <= rst_shl;
                    end else begin
                        timer <= t_inc;
                    end
                end
                RELEASE: begin
                    if (!lock_s) begin
                        state   <= RST_PLL;
                        timer   <= '0;
                        rst_out <= '1;
                    end else if (rst_out == '0) begin
                        state     <= RUN;
                        retry_cnt <= '0;
                    end else if (timer >= T_GAP) begin
                        timer   <= '0;
                        rst_out <= rst_shl;
                        if (rst_shl == '0) begin
                            state     <= RUN;
                            retry_cnt <= '0;
                        end
                    end else begin
                        timer <= t_inc;
                    end
                end
                RUN: begin
                    retry_cnt <= '0;
                    if (!lock_s) begin
                        state   <= RST_PLL;
                        timer   <= '0;
                        rst_out <= '1;
                    end
                end
                FAIL: begin
                    rst_out <= '1;
                end
                default: begin
                    state   <= RST_PLL;
                    timer   <= '0;
                    rst_out <= '1;
                end
            endcase
        end
    end

`ifdef CLKGEN_LOSS_CNT_EN
    // Count RUN -> RST_PLL lock-loss events, saturating.
    always_ff @(posedge clkin) begin
        if (reset)
            loss_cnt <= '0;
        else if (state == RUN && !lock_s && loss_cnt != 16'hFFFF)
            loss_cnt <= loss_cnt + 16'd1;
    end
`endif

endmodule
